// File: rtl/xgriscv_divider.sv
`default_nettype none
// ============================================================================
// Module   : xgriscv_divider
// Purpose  : Multi-cycle radix-2 restoring divider for the execute stage.
//            Implements RV32M DIV / DIVU / REM / REMU, one quotient bit per
//            cycle. Divide-by-zero and signed overflow complete immediately.
// Ports    : clk    - core clock, rising edge
//            reset  - synchronous active-high reset
//            start  - issue request, honoured only while busy=0
//            op     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//            a, b   - dividend / divisor, captured on accepted start
//            flush  - abort any in-flight operation
//            busy   - operation in progress (CALC or FIX)
//            done   - one-cycle completion pulse
//            result - quotient or remainder, held until next completion
// Revision : 1.0 - initial release
// ============================================================================
module xgriscv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] c_ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_divisor;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_sel_rem;
    logic [XLEN-1:0]    r_result;

    logic               w_accept;
    logic               w_signed;
    logic [XLEN-1:0]    w_a_abs;
    logic [XLEN-1:0]    w_b_abs;
    logic               w_div_zero;
    logic               w_overflow;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_trial;
    logic [XLEN-1:0]    w_quo_fix;
    logic [XLEN-1:0]    w_rem_fix;

    // Only IDLE and DONE can take a new request; flush blocks acceptance.
    assign w_accept   = start && !flush && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_signed   = !op[0];
    assign w_a_abs    = (w_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign w_b_abs    = (w_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    assign w_div_zero = (b == '0);
    assign w_overflow = w_signed && (a == c_MIN_NEG) && (b == c_ONES);

    // Partial remainder is always below the divisor, so the shifted value
    // plus one extra bit is enough to hold the trial subtraction.
    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};

    assign w_quo_fix  = r_q_neg ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix  = r_r_neg ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_result  <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else if (w_accept) begin
            r_sel_rem <= op[1];
            if (w_div_zero) begin
                r_result <= op[1] ? a : c_ONES;
                r_state  <= S_DONE;
            end else if (w_overflow) begin
                r_result <= op[1] ? '0 : a;
                r_state  <= S_DONE;
            end else begin
                r_rem     <= '0;
                r_quo     <= w_a_abs;
                r_divisor <= w_b_abs;
                r_cnt     <= c_CNT_INIT;
                r_q_neg   <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
                r_r_neg   <= w_signed && a[XLEN-1];
                r_state   <= S_CALC;
            end
        end else begin
            case (r_state)
                S_CALC: begin
                    // Dividend bits shift out of quo into rem while quotient
                    // bits shift in at the bottom.
                    if (!w_trial[XLEN]) begin
                        r_rem <= w_trial[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule
`default_nettype wire
